// File: rtl/nids_axi_pkg.sv
// AXI3 constants, FSM state type and ring-pointer helper shared by the
// NIDS f2h write master.
package nids_axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [3:0] CACHE_BUF   = 4'b0011;
  localparam logic [2:0] PROT_DATA   = 3'b000;
  localparam logic [1:0] LOCK_NORMAL = 2'b00;
  localparam logic [4:0] USER_NONE   = 5'b00000;
  localparam logic [7:0] STRB_ALL    = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  // Advance a byte offset by one burst slot, wrapping to zero at the ring end.
  function automatic logic [31:0] ring_advance(input logic [31:0] ptr,
                                               input logic [31:0] step,
                                               input logic [31:0] size);
    logic [31:0] sum;
    sum = ptr + step;
    return (sum == size) ? 32'h0000_0000 : sum;
  endfunction

endpackage

// File: rtl/nids_f2h_wr_master_if.sv
// AXI3 write-channel bundle (AW, W, B) between the NIDS write master and
// the HPS f2h slave port.
interface nids_f2h_wr_master_if;
  logic [7:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [4:0]  awuser;
  logic        awvalid;
  logic        awready;
  logic [7:0]  wid;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awuser, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/nids_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count and a registered
// not-full flag that stays low while in reset.
module nids_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  output logic                     not_full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_idx_r;
  logic [AW-1:0]    rd_idx_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_nxt_s;
  logic             not_full_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign push_ok_s   = push & not_full_r;
  assign pop_ok_s    = pop & (count_r != {CW{1'b0}});
  assign count_nxt_s = count_r + CW'(push_ok_s) - CW'(pop_ok_s);

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_idx_r] <= din;
    end
  end

  // Pointers, occupancy and registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx_r   <= {AW{1'b0}};
      rd_idx_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      not_full_r <= 1'b0;
    end else begin
      wr_idx_r   <= push_ok_s ? wr_idx_r + AW'(1'b1) : wr_idx_r;
      rd_idx_r   <= pop_ok_s ? rd_idx_r + AW'(1'b1) : rd_idx_r;
      count_r    <= count_nxt_s;
      not_full_r <= (count_nxt_s != CW'(DEPTH));
    end
  end

  assign dout     = mem_r[rd_idx_r];
  assign count    = count_r;
  assign not_full = not_full_r;
endmodule

// File: rtl/nids_f2h_wr_master.sv
// Drains the NIDS 64-bit record stream into an HPS DDR ring buffer with
// AXI3 INCR bursts and publishes the ring write pointer.
module nids_f2h_wr_master
  import nids_axi_pkg::*;
#(
  parameter logic [7:0] AXI_ID     = 8'h00,
  parameter int         BURST_LEN  = 16,
  parameter int         FIFO_DEPTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [31:0]                 ring_base,
  input  logic [31:0]                 ring_size,
  input  logic                        flush,
  input  logic [63:0]                 s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [31:0]                 wr_ptr,
  output logic [31:0]                 burst_cnt,
  output logic                        err,
  nids_f2h_wr_master_if.master        axi
);
  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);

  wr_state_e   state_r, state_nxt_s;
  logic [CW-1:0] count_s;
  logic [63:0] head_s;
  logic        pop_s;
  logic        flush_pend_r, enable_d_r;
  logic        enable_rise_s, launch_s, aw_hs_s, w_hs_s, b_hs_s;
  logic [4:0]  take_s;

  logic [31:0] awaddr_r, awaddr_nxt_s;
  logic [3:0]  awlen_r, awlen_nxt_s;
  logic        awvalid_r, awvalid_nxt_s;
  logic [63:0] wdata_r, wdata_nxt_s;
  logic        wlast_r, wlast_nxt_s, wvalid_r, wvalid_nxt_s;
  logic        bready_r, bready_nxt_s;
  logic [4:0]  nbeats_r, nbeats_nxt_s, beat_idx_r, beat_idx_nxt_s;
  logic [31:0] wr_ptr_r, wr_ptr_nxt_s, burst_cnt_r, burst_cnt_nxt_s;
  logic        err_r, err_nxt_s;
  logic        unused_bid_s;

  nids_sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(s_valid), .din(s_data), .not_full(s_ready),
    .pop(pop_s), .dout(head_s), .count(count_s)
  );

  assign enable_rise_s = enable & ~enable_d_r & (state_r == ST_IDLE);
  assign launch_s      = (state_r == ST_IDLE) & enable &
                         ((count_s >= CW'(BURST_LEN)) | (flush_pend_r & (count_s != {CW{1'b0}})));
  assign take_s        = (count_s >= CW'(BURST_LEN)) ? 5'(BURST_LEN) : 5'(count_s);
  assign aw_hs_s       = awvalid_r & axi.awready;
  assign w_hs_s        = wvalid_r & axi.wready;
  assign b_hs_s        = bready_r & axi.bvalid;
  assign unused_bid_s  = ^axi.bid;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic: one outstanding burst at a time.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: state_nxt_s = launch_s ? ST_ADDR : ST_IDLE;
      ST_ADDR: state_nxt_s = aw_hs_s ? ST_DATA : ST_ADDR;
      ST_DATA: state_nxt_s = (w_hs_s && wlast_r) ? ST_RESP : ST_DATA;
      ST_RESP: state_nxt_s = b_hs_s ? ST_IDLE : ST_RESP;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered AXI outputs and status.
  always_comb begin
    awvalid_nxt_s = awvalid_r;   awaddr_nxt_s   = awaddr_r;   awlen_nxt_s     = awlen_r;
    nbeats_nxt_s  = nbeats_r;    wvalid_nxt_s   = wvalid_r;   wdata_nxt_s     = wdata_r;
    wlast_nxt_s   = wlast_r;     beat_idx_nxt_s = beat_idx_r; bready_nxt_s    = bready_r;
    wr_ptr_nxt_s  = wr_ptr_r;    err_nxt_s      = err_r;      burst_cnt_nxt_s = burst_cnt_r;
    pop_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable_rise_s) begin
          wr_ptr_nxt_s = 32'h0; burst_cnt_nxt_s = 32'h0; err_nxt_s = 1'b0;
        end else begin
          wr_ptr_nxt_s = wr_ptr_r;
        end
        if (launch_s) begin
          awvalid_nxt_s = 1'b1;
          nbeats_nxt_s  = take_s;
          awlen_nxt_s   = 4'(take_s - 5'd1);
          awaddr_nxt_s  = ring_base + (enable_rise_s ? 32'h0 : wr_ptr_r);
        end else begin
          awvalid_nxt_s = 1'b0;
        end
      end
      ST_ADDR: begin
        // The first beat is prefetched into the W register on the AW handshake.
        if (aw_hs_s) begin
          awvalid_nxt_s = 1'b0; wvalid_nxt_s = 1'b1; wdata_nxt_s = head_s; pop_s = 1'b1;
          wlast_nxt_s = (nbeats_r == 5'd1); beat_idx_nxt_s = 5'd0;
        end else begin
          awvalid_nxt_s = 1'b1;
        end
      end
      ST_DATA: begin
        if (w_hs_s && wlast_r) begin
          wvalid_nxt_s = 1'b0; wlast_nxt_s = 1'b0; bready_nxt_s = 1'b1;
        end else if (w_hs_s) begin
          wdata_nxt_s = head_s; pop_s = 1'b1; beat_idx_nxt_s = beat_idx_r + 5'd1;
          wlast_nxt_s = ((beat_idx_r + 5'd2) == nbeats_r);
        end else begin
          wvalid_nxt_s = wvalid_r;
        end
      end
      ST_RESP: begin
        // Partial bursts still consume a full slot so bursts never cross 4 KB.
        if (b_hs_s) begin
          bready_nxt_s    = 1'b0;
          wr_ptr_nxt_s    = ring_advance(wr_ptr_r, BURST_BYTES, ring_size);
          burst_cnt_nxt_s = burst_cnt_r + 32'd1;
          err_nxt_s       = err_r | (axi.bresp != RESP_OKAY);
        end else begin
          bready_nxt_s = 1'b1;
        end
      end
      default: begin
        awvalid_nxt_s = 1'b0; wvalid_nxt_s = 1'b0; wlast_nxt_s = 1'b0; bready_nxt_s = 1'b0;
      end
    endcase
  end

  // Output and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awvalid_r <= 1'b0;  awaddr_r <= 32'h0;  awlen_r <= 4'h0;  nbeats_r <= 5'd0;
      wvalid_r  <= 1'b0;  wdata_r  <= 64'h0;  wlast_r <= 1'b0;  beat_idx_r <= 5'd0;
      bready_r  <= 1'b0;  wr_ptr_r <= 32'h0;  burst_cnt_r <= 32'h0;  err_r <= 1'b0;
      flush_pend_r <= 1'b0;  enable_d_r <= 1'b0;
    end else begin
      awvalid_r <= awvalid_nxt_s;  awaddr_r <= awaddr_nxt_s;  awlen_r <= awlen_nxt_s;
      nbeats_r  <= nbeats_nxt_s;   wvalid_r <= wvalid_nxt_s;  wdata_r <= wdata_nxt_s;
      wlast_r   <= wlast_nxt_s;    beat_idx_r <= beat_idx_nxt_s;  bready_r <= bready_nxt_s;
      wr_ptr_r  <= wr_ptr_nxt_s;   burst_cnt_r <= burst_cnt_nxt_s;  err_r <= err_nxt_s;
      flush_pend_r <= flush ? 1'b1 : (launch_s ? 1'b0 : flush_pend_r);
      enable_d_r   <= enable;
    end
  end

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = awaddr_r;
  assign axi.awlen   = awlen_r;
  assign axi.awsize  = SIZE_8B;
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = LOCK_NORMAL;
  assign axi.awcache = CACHE_BUF;
  assign axi.awprot  = PROT_DATA;
  assign axi.awuser  = USER_NONE;
  assign axi.awvalid = awvalid_r;
  assign axi.wid     = AXI_ID;
  assign axi.wdata   = wdata_r;
  assign axi.wstrb   = STRB_ALL;
  assign axi.wlast   = wlast_r;
  assign axi.wvalid  = wvalid_r;
  assign axi.bready  = bready_r;
  assign wr_ptr      = wr_ptr_r;
  assign burst_cnt   = burst_cnt_r;
  assign err         = err_r;
endmodule

// File: tb/tb_nids_f2h_wr_master.sv
// Scoreboard bench for nids_f2h_wr_master: stimulus queues expected AW/W
// traffic, a negedge monitor pops and compares on every handshake.
module tb_nids_f2h_wr_master;
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, flush = 1'b0, s_valid = 1'b0;
  logic [31:0] ring_base = 32'h3000_0000, ring_size = 32'h0000_0800;
  logic [63:0] s_data = 64'h0;
  logic        s_ready, err;
  logic [31:0] wr_ptr, burst_cnt;

  nids_f2h_wr_master_if axi ();

  nids_f2h_wr_master #(.AXI_ID(8'h00), .BURST_LEN(16), .FIFO_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ring_base(ring_base), .ring_size(ring_size),
    .flush(flush), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_ptr(wr_ptr), .burst_cnt(burst_cnt), .err(err), .axi(axi)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  logic [35:0] exp_aw_q[$];
  logic [64:0] exp_w_q[$];
  int push_ctr = 0, exp_word = 0, w_hs_cnt = 0;
  logic [31:0] exp_ptr = 32'h0;
  int b_owed = 0, b_idx = 0, err_burst = -1;
  bit stall_en = 1'b0, b_hs_n = 1'b0, wl_hs_n = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_burst(input int n);
    exp_aw_q.push_back({ring_base + exp_ptr, 4'(n - 1)});
    for (int k = 0; k < n; k++) begin
      exp_w_q.push_back({(k == n - 1), 64'(exp_word)});
      exp_word++;
    end
    exp_ptr = (exp_ptr + 32'h80 == ring_size) ? 32'h0 : exp_ptr + 32'h80;
  endtask

  task automatic push_words(input int n);
    bit done;
    int guard;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1; s_data = 64'(push_ctr); done = 1'b0; guard = 0;
      while (!done) begin
        @(negedge clk);
        if (s_ready) begin
          @(posedge clk); #1; done = 1'b1;
        end else if (++guard > 3000) begin
          n_checks++; n_fail++;
          $display("FAIL push_timeout: word %0d never accepted", push_ctr);
          s_valid = 1'b0;
          return;
        end
      end
      push_ctr++;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_bursts(input int n, input string name);
    int g = 0;
    while (burst_cnt != 32'(n) && g < 3000) begin @(negedge clk); g++; end
    check(name, 64'(burst_cnt), 64'(n));
    @(posedge clk); #1;
  endtask

  task automatic toggle_enable();
    enable = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    enable = 1'b1; exp_ptr = 32'h0;
    @(posedge clk); #1;
  endtask

  // Monitor: scoreboard compare plus VALID stability and AW->W latency checks.
  initial begin
    logic aw_pend_p, w_pend_p, aw_hs_p, wlast_p;
    logic [31:0] awaddr_p;
    logic [63:0] wdata_p;
    logic [35:0] ea;
    logic [64:0] ew;
    aw_pend_p = 1'b0; w_pend_p = 1'b0; aw_hs_p = 1'b0;
    awaddr_p = 32'h0; wdata_p = 64'h0; wlast_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_pend_p = 1'b0; w_pend_p = 1'b0; aw_hs_p = 1'b0; b_hs_n = 1'b0; wl_hs_n = 1'b0;
      end else begin
        if (aw_pend_p) begin
          check("aw_stable_valid", 64'(axi.awvalid), 64'd1);
          check("aw_stable_addr", 64'(axi.awaddr), 64'(awaddr_p));
        end
        if (w_pend_p) begin
          check("w_stable_valid", 64'(axi.wvalid), 64'd1);
          check("w_stable_data", axi.wdata, wdata_p);
          check("w_stable_last", 64'(axi.wlast), 64'(wlast_p));
        end
        if (aw_hs_p) check("w_after_aw", 64'(axi.wvalid), 64'd1);
        if (axi.awvalid && axi.awready) begin
          if (exp_aw_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL aw_unexpected: got awaddr 0x%0h, expected no burst", axi.awaddr);
          end else begin
            ea = exp_aw_q.pop_front();
            check("awaddr", 64'(axi.awaddr), 64'(ea[35:4]));
            check("awlen", 64'(axi.awlen), 64'(ea[3:0]));
          end
        end
        if (axi.wvalid && axi.wready) begin
          w_hs_cnt++;
          if (exp_w_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL w_unexpected: got wdata 0x%0h, expected no beat", axi.wdata);
          end else begin
            ew = exp_w_q.pop_front();
            check("wdata", axi.wdata, ew[63:0]);
            check("wlast", 64'(axi.wlast), 64'(ew[64]));
          end
        end
        aw_pend_p = axi.awvalid & ~axi.awready; awaddr_p = axi.awaddr;
        w_pend_p  = axi.wvalid & ~axi.wready;   wdata_p = axi.wdata; wlast_p = axi.wlast;
        aw_hs_p   = axi.awvalid & axi.awready;
        b_hs_n    = axi.bvalid & axi.bready;
        wl_hs_n   = axi.wvalid & axi.wready & axi.wlast;
      end
    end
  end

  // Slave model: ready/valid with optional random stalls, one B per burst.
  initial begin
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        b_owed = 0; axi.bvalid = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
      end else begin
        if (b_hs_n) begin axi.bvalid = 1'b0; b_owed--; b_idx++; end
        if (wl_hs_n) b_owed++;
        axi.awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.wready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!axi.bvalid && b_owed > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (b_idx == err_burst) ? 2'b10 : 2'b00;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, g;
    // Reset values and constant AXI fields
    #7;
    check("rst_awvalid", 64'(axi.awvalid), 64'd0);
    check("rst_wvalid", 64'(axi.wvalid), 64'd0);
    check("rst_bready", 64'(axi.bready), 64'd0);
    check("rst_wr_ptr", 64'(wr_ptr), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("awsize", 64'(axi.awsize), 64'd3);
    check("awburst", 64'(axi.awburst), 64'd1);
    check("awcache", 64'(axi.awcache), 64'd3);
    check("wstrb", 64'(axi.wstrb), 64'hFF);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_rst", 64'(s_ready), 64'd1);
    enable = 1'b1;
    @(posedge clk); #1;

    // One full burst of words 0..15
    expect_burst(16);
    push_words(16);
    wait_bursts(1, "t1_burst_cnt");
    check("t1_wr_ptr", 64'(wr_ptr), 64'h80);

    // Partial burst forced by flush
    expect_burst(5);
    push_words(5);
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    wait_bursts(2, "t2_burst_cnt");
    check("t2_wr_ptr", 64'(wr_ptr), 64'h100);

    // Ring wrap after 16 bursts
    toggle_enable();
    check("t3_clr_ptr", 64'(wr_ptr), 64'd0);
    for (int b = 0; b < 16; b++) expect_burst(16);
    push_words(256);
    wait_bursts(16, "t3_burst_cnt16");
    check("t3_wrap_ptr", 64'(wr_ptr), 64'd0);
    expect_burst(16);
    push_words(16);
    wait_bursts(17, "t3_burst_cnt17");
    check("t3_ptr_after_wrap", 64'(wr_ptr), 64'h80);

    // FIFO full with enable low, then drain under random stalls
    enable = 1'b0;
    push_words(32);
    @(negedge clk);
    check("t4_full_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    stall_en = 1'b1; enable = 1'b1; exp_ptr = 32'h0;
    for (int b = 0; b < 4; b++) expect_burst(16);
    push_words(32);
    wait_bursts(4, "t4_burst_cnt");
    check("t4_wr_ptr", 64'(wr_ptr), 64'h200);
    stall_en = 1'b0;

    // SLVERR on the second burst
    toggle_enable();
    err_burst = b_idx + 1;
    expect_burst(16);
    push_words(16);
    wait_bursts(1, "t5_burst_cnt1");
    check("t5_err_before", 64'(err), 64'd0);
    expect_burst(16); expect_burst(16);
    push_words(32);
    wait_bursts(3, "t5_burst_cnt3");
    check("t5_err_sticky", 64'(err), 64'd1);
    check("t5_wr_ptr", 64'(wr_ptr), 64'h180);
    err_burst = -1;
    toggle_enable();
    check("t5_err_cleared", 64'(err), 64'd0);
    check("t5_cnt_cleared", 64'(burst_cnt), 64'd0);

    // Reset during beat 7 of a burst
    expect_burst(16);
    push_words(16);
    wait_bursts(1, "t6_burst_cnt1");
    expect_burst(16);
    w0 = w_hs_cnt;
    push_words(16);
    g = 0;
    while (w_hs_cnt < w0 + 6 && g < 1000) begin @(negedge clk); g++; end
    check("t6_reached_beat7", 64'(w_hs_cnt >= w0 + 6), 64'd1);
    #2; rst_n = 1'b0; #1;
    check("t6_rst_wvalid", 64'(axi.wvalid), 64'd0);
    check("t6_rst_wlast", 64'(axi.wlast), 64'd0);
    check("t6_rst_awvalid", 64'(axi.awvalid), 64'd0);
    check("t6_rst_bready", 64'(axi.bready), 64'd0);
    check("t6_rst_wr_ptr", 64'(wr_ptr), 64'd0);
    check("t6_rst_burst_cnt", 64'(burst_cnt), 64'd0);
    check("t6_rst_s_ready", 64'(s_ready), 64'd0);
    exp_aw_q.delete(); exp_w_q.delete(); exp_ptr = 32'h0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    expect_burst(16);
    push_words(16);
    wait_bursts(1, "t6_post_rst_cnt");
    check("t6_post_rst_ptr", 64'(wr_ptr), 64'h80);

    repeat (4) begin @(posedge clk); #1; end
    check("aw_q_drained", 64'(exp_aw_q.size()), 64'd0);
    check("w_q_drained", 64'(exp_w_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
